// File: rtl/tm1638_refresh_sequencer.sv
// Streams the TM1638 display image plus display-control setting as 17-bit command
// words, one frame per refresh period or on host request.
module tm1638_refresh_sequencer #(
  parameter int REFRESH_PERIOD = 1_000_000,
  parameter int CNT_W          = $clog2(REFRESH_PERIOD + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [7:0]  wr_data_i,
  input  logic        show_i,
  input  logic [2:0]  brightness_i,
  input  logic        refresh_req_i,
  output logic        cmd_valid_o,
  output logic [16:0] cmd_word_o,
  input  logic        cmd_ready_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_CTRL  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [16:0]      DATA_CMD_WORD = 17'h00044;
  localparam logic [CNT_W-1:0] CNT_LOAD      = CNT_W'(REFRESH_PERIOD - 1);

  logic [2:0]       state;
  logic [3:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic [7:0]       shadow [16];

  logic [3:0]  next_idx;
  logic [16:0] addr_word;
  logic [16:0] ctrl_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow[i] <= 8'h00;
    end else if (wr_en_i) begin
      shadow[wr_addr_i] <= wr_data_i;
    end
  end

  // Index of the ADDR word to present next; DATA_CMD hands over to index 0.
  always_comb begin
    next_idx  = (state == S_DATA) ? 4'd0 : idx + 4'd1;
    addr_word = {1'b1, shadow[next_idx], 4'hC, next_idx};
    ctrl_word = {1'b0, 8'h00, 2'b10, 2'b00, show_i, brightness_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_START;
      idx          <= 4'd0;
      cnt          <= CNT_LOAD;
      pending      <= 1'b0;
      cmd_valid_o  <= 1'b0;
      cmd_word_o   <= 17'h0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (refresh_req_i && state != S_WAIT) pending <= 1'b1;
      case (state)
        S_START: begin
          state       <= S_DATA;
          cmd_valid_o <= 1'b1;
          cmd_word_o  <= DATA_CMD_WORD;
          busy_o      <= 1'b1;
        end
        S_DATA, S_ADDR: begin
          // A transfer drops valid for one cycle; the next word follows after it.
          if (cmd_valid_o) begin
            if (cmd_ready_i) cmd_valid_o <= 1'b0;
          end else if (state == S_ADDR && idx == 4'd15) begin
            state       <= S_CTRL;
            cmd_valid_o <= 1'b1;
            cmd_word_o  <= ctrl_word;
          end else begin
            state       <= S_ADDR;
            idx         <= next_idx;
            cmd_valid_o <= 1'b1;
            cmd_word_o  <= addr_word;
          end
        end
        S_CTRL: begin
          if (cmd_ready_i) begin
            state        <= S_WAIT;
            cmd_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b1;
            cnt          <= CNT_LOAD;
          end
        end
        S_WAIT: begin
          if (refresh_req_i || pending || cnt == '0) begin
            state       <= S_DATA;
            cmd_valid_o <= 1'b1;
            cmd_word_o  <= DATA_CMD_WORD;
            busy_o      <= 1'b1;
            pending     <= 1'b0;
            cnt         <= CNT_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_refresh_sequencer.sv
// Scoreboard bench for tm1638_refresh_sequencer: stimulus queues expected words,
// a negedge monitor pops and compares on every accepted transfer.
module tb_tm1638_refresh_sequencer;

  localparam int P = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        show;
  logic [2:0]  bri;
  logic        req;
  logic        valid;
  logic [16:0] word;
  logic        ready;
  logic        busy;
  logic        done;

  typedef struct {
    logic [16:0] w;
    int          gap;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       e;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_xfer = -100;
  logic       last_ctrl = 1'b0;
  int         done_cnt = 0;
  logic [7:0] model [16];

  tm1638_refresh_sequencer #(.REFRESH_PERIOD(P)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .show_i        (show),
    .brightness_i  (bri),
    .refresh_req_i (req),
    .cmd_valid_o   (valid),
    .cmd_word_o    (word),
    .cmd_ready_i   (ready),
    .busy_o        (busy),
    .frame_done_o  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int gap, input logic [16:0] ctrl);
    sb_q.push_back('{w: 17'h00044, gap: gap});
    for (int i = 0; i < 16; i++)
      sb_q.push_back('{w: {1'b1, model[i], 4'hC, 4'(i)}, gap: 0});
    sb_q.push_back('{w: ctrl, gap: 0});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      tick;
      n++;
    end while (done !== 1'b1 && n < 400);
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s: got no frame_done expected pulse", name);
    end
  endtask

  task automatic wait_word(input logic [16:0] w);
    int n = 0;
    do begin
      tick;
      n++;
    end while (!(valid === 1'b1 && word === w) && n < 400);
    if (!(valid === 1'b1 && word === w)) begin
      tests++;
      fails++;
      $display("FAIL timeout_word: got %05h expected %05h", word, w);
    end
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        check("busy_during_word", busy, 1);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %05h expected none", word);
        end else begin
          e = sb_q.pop_front();
          check("word", word, e.w);
          if (e.gap != 0) check("gap_since_prev", cyc - last_xfer, e.gap);
        end
        last_xfer = cyc;
        last_ctrl = (word[16] == 1'b0 && word[7:6] == 2'b10);
      end
      if (done) begin
        done_cnt++;
        check("done_after_ctrl", last_ctrl, 1);
        check("done_timing", cyc - last_xfer, 1);
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    show = 1'b1; bri = 3'd0; req = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid, 0);
    check("reset_word", word, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Frame 1: all-zero image, show=1 brightness=0.
    push_frame(0, 17'h00088);
    rst_n = 1'b1;
    wait_done("f1");

    // Frame 2: shadow writes during WAIT, normal period gap, backpressure on C3.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3F; model[5] = 8'h3F;
    tick;
    wr_addr = 4'd14; wr_data = 8'h06; model[14] = 8'h06;
    tick;
    wr_en = 1'b0;
    push_frame(P + 1, 17'h00088);
    wait_word(17'h100C3);
    ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("bp_valid", valid, 1);
      check("bp_word", word, 17'h100C3);
      tick;
    end
    ready = 1'b1;
    wait_done("f2");

    // Frame 3: refresh request in WAIT, new control setting.
    show = 1'b0; bri = 3'd5;
    push_frame(0, 17'h00085);
    req = 1'b1;
    tick;
    req = 1'b0;
    check("req_wait_valid", valid, 1);
    check("req_wait_word", word, 17'h00044);
    for (int k = 0; k < 3; k++) begin
      tick; req = 1'b1;
      tick; req = 1'b0;
    end
    // Three coalesced requests: one extra frame after a single idle cycle.
    push_frame(2, 17'h00085);
    push_frame(P + 1, 17'h00085);
    wait_done("f3");
    wait_done("f4");

    // Frame 5: reset while an ADDR word is stalled.
    wait_word(17'h100C2);
    ready = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    check("abort_valid", valid, 0);
    check("abort_word", word, 0);
    check("abort_busy", busy, 0);
    sb_q.delete();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    tick;
    tick;
    ready = 1'b1;
    push_frame(0, 17'h00085);
    rst_n = 1'b1;
    wait_done("f6");
    tick;

    check("frame_done_count", done_cnt, 5);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
